spongent_stream: RTL and testbench

Streaming Spongent sponge-hash core. It absorbs a message of arbitrary length as R_BITS-wide blocks over a valid/ready handshake and applies padding in hardware. It computes one permutation round per cycle and squeezes an N-bit digest. It generalises the fixed-length hash core: the message length is open-ended, the rate, capacity, digest width and round count are parametric, and the start/done control lets one instance hash back-to-back messages.

---
 rtl/spongent_pkg.sv | 51 +++++
 rtl/spongent_stream_if.sv | 27 ++
 rtl/spongent_round.sv | 29 ++
 rtl/spongent_stream.sv | 151 +++++++++++++++
 tb/tb_spongent_stream.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spongent_pkg.sv
// Shared types and combinational helpers for the streaming Spongent core:
// FSM encoding, S-box, pLayer bit permutation and round-constant LFSR step.
package spongent_pkg;

    localparam int unsigned MAX_B   = 512;
    localparam int unsigned MAX_B_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_PERM,
        S_SQUEEZE,
        S_DONE
    } state_e;

    localparam logic [3:0] SBOX_LUT [16] = '{
        4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
        4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
    };

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_LUT[x];
    endfunction

    // Bit j moves to (j*b/4) mod (b-1); the top bit of the b-bit state is fixed.
    function automatic logic [MAX_B-1:0] p_layer(input logic [MAX_B-1:0] s,
                                                 input int unsigned b);
        logic [MAX_B-1:0] r;
        r = '0;
        for (int unsigned j = 0; j < MAX_B; j++) begin
            if (j < b - 1)
                r[MAX_B_W'((j * b / 4) % (b - 1))] = s[MAX_B_W'(j)];
            else if (j == b - 1)
                r[MAX_B_W'(j)] = s[MAX_B_W'(j)];
        end
        return r;
    endfunction

    // Galois-style shift-left LFSR of width w (w <= 32); poly bit w is dropped.
    function automatic logic [31:0] lfsr_step(input logic [31:0] lc,
                                              input logic [31:0] poly,
                                              input int unsigned w);
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        nxt  = {lc[30:0], 1'b0} ^ (lc[5'(w - 1)] ? poly : 32'd0);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/spongent_stream_if.sv
// Message/digest bus of the streaming Spongent core.
interface spongent_stream_if #(
    parameter int unsigned R_BITS = 16,
    parameter int unsigned N      = 256
);
    localparam int unsigned KB_W = $clog2(R_BITS + 1);

    logic              start;
    logic              msg_valid;
    logic              msg_ready;
    logic [R_BITS-1:0] msg_data;
    logic              msg_last;
    logic [KB_W-1:0]   msg_last_bits;
    logic              busy;
    logic              hash_valid;
    logic [N-1:0]      hash;

    modport master (
        output start, msg_valid, msg_data, msg_last, msg_last_bits,
        input  msg_ready, busy, hash_valid, hash
    );

    modport slave (
        input  start, msg_valid, msg_data, msg_last, msg_last_bits,
        output msg_ready, busy, hash_valid, hash
    );
endinterface

// File: rtl/spongent_round.sv
// One combinational Spongent round: constant injection, S-box layer, pLayer.
module spongent_round
    import spongent_pkg::*;
#(
    parameter int unsigned B        = 272,
    parameter int unsigned LC_WIDTH = 8
) (
    input  logic [B-1:0]        state_in,
    input  logic [LC_WIDTH-1:0] lc,
    output logic [B-1:0]        state_out
);

    logic [LC_WIDTH-1:0] lc_rev;
    logic [B-1:0]        const_c;
    logic [B-1:0]        sb_c;

    for (genvar g = 0; g < LC_WIDTH; g++) begin : g_rev
        assign lc_rev[g] = lc[LC_WIDTH-1-g];
    end

    assign const_c = state_in ^ {lc_rev, {(B - 2 * LC_WIDTH){1'b0}}, lc};

    for (genvar g = 0; g < B / 4; g++) begin : g_sbox
        assign sb_c[4*g +: 4] = sbox(const_c[4*g +: 4]);
    end

    assign state_out = B'(p_layer(MAX_B'(sb_c), B));

endmodule

// File: rtl/spongent_stream.sv
// Streaming Spongent sponge: absorbs padded rate blocks, one round per cycle,
// squeezes an N-bit digest; start in IDLE/DONE begins a new message.
module spongent_stream
    import spongent_pkg::*;
#(
    parameter int unsigned          N        = 256,
    parameter int unsigned          C        = 256,
    parameter int unsigned          R_BITS   = 16,
    parameter int unsigned          ROUNDS   = 140,
    parameter int unsigned          LC_WIDTH = 8,
    parameter logic [LC_WIDTH-1:0]  LC_INIT  = 8'h9E,
    parameter logic [LC_WIDTH:0]    LC_POLY  = 9'h11D
) (
    input logic               clk,
    input logic               rst,
    spongent_stream_if.slave  bus
);

    localparam int unsigned B    = C + R_BITS;
    localparam int unsigned K    = N / R_BITS;
    localparam int unsigned KB_W = $clog2(R_BITS + 1);
    localparam int unsigned RC_W = $clog2(ROUNDS + 1);
    localparam int unsigned CC_W = $clog2(K + 1);
    localparam logic [R_BITS-1:0] PAD_BLK = {1'b1, {(R_BITS - 1){1'b0}}};

    state_e              st;
    logic [B-1:0]        sreg;
    logic [LC_WIDTH-1:0] lc;
    logic [RC_W-1:0]     round_cnt;
    logic [CC_W-1:0]     chunk_cnt;
    logic                last_done;
    logic                pad_pending;
    logic                ready_q;
    logic                busy_q;
    logic                hv_q;
    logic [N-1:0]        hash_q;

    logic [B-1:0]        round_out;
    logic [KB_W-1:0]     k_c;
    logic [R_BITS-1:0]   block_c;
    logic [R_BITS-1:0]   absorb_c;
    logic [R_BITS-1:0]   pad_sw_c;
    logic [R_BITS-1:0]   chunk_c;

    // Final block keeps its top k bits, then a single 1, then zeros.
    always_comb begin
        k_c     = (bus.msg_last_bits > KB_W'(R_BITS)) ? KB_W'(R_BITS) : bus.msg_last_bits;
        block_c = bus.msg_data;
        if (bus.msg_last)
            block_c = (bus.msg_data & ~({R_BITS{1'b1}} >> k_c))
                    | R_BITS'({1'b1, {R_BITS{1'b0}}} >> (k_c + KB_W'(1)));
    end

    // Byte order reversal between the bus and the low rate bits of the state.
    for (genvar g = 0; g < R_BITS / 8; g++) begin : g_swap
        assign absorb_c[8*g +: 8] = block_c[R_BITS-8-8*g +: 8];
        assign pad_sw_c[8*g +: 8] = PAD_BLK[R_BITS-8-8*g +: 8];
        assign chunk_c[8*g +: 8]  = sreg[R_BITS-8-8*g +: 8];
    end

    spongent_round #(.B(B), .LC_WIDTH(LC_WIDTH)) u_round (
        .state_in  (sreg),
        .lc        (lc),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_IDLE;
            sreg        <= '0;
            lc          <= LC_INIT;
            round_cnt   <= '0;
            chunk_cnt   <= '0;
            last_done   <= 1'b0;
            pad_pending <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            hv_q        <= 1'b0;
            hash_q      <= '0;
        end else begin
            case (st)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        st          <= S_ABSORB;
                        sreg        <= '0;
                        hash_q      <= '0;
                        chunk_cnt   <= '0;
                        last_done   <= 1'b0;
                        pad_pending <= 1'b0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        hv_q        <= 1'b0;
                    end
                end
                S_ABSORB: begin
                    if (bus.msg_valid && ready_q) begin
                        sreg[R_BITS-1:0] <= sreg[R_BITS-1:0] ^ absorb_c;
                        last_done        <= bus.msg_last;
                        pad_pending      <= bus.msg_last && (k_c == KB_W'(R_BITS));
                        st               <= S_PERM;
                        lc               <= LC_INIT;
                        round_cnt        <= '0;
                        ready_q          <= 1'b0;
                    end
                end
                S_PAD: begin
                    sreg[R_BITS-1:0] <= sreg[R_BITS-1:0] ^ pad_sw_c;
                    pad_pending      <= 1'b0;
                    st               <= S_PERM;
                    lc               <= LC_INIT;
                    round_cnt        <= '0;
                end
                S_PERM: begin
                    sreg      <= round_out;
                    lc        <= LC_WIDTH'(lfsr_step(32'(lc), 32'(LC_POLY), LC_WIDTH));
                    round_cnt <= round_cnt + RC_W'(1);
                    if (round_cnt == RC_W'(ROUNDS - 1)) begin
                        if (!last_done) begin
                            st      <= S_ABSORB;
                            ready_q <= 1'b1;
                        end else if (pad_pending) begin
                            st <= S_PAD;
                        end else begin
                            st <= S_SQUEEZE;
                        end
                    end
                end
                S_SQUEEZE: begin
                    hash_q    <= N'({hash_q, chunk_c});
                    chunk_cnt <= chunk_cnt + CC_W'(1);
                    if (chunk_cnt == CC_W'(K - 1)) begin
                        st     <= S_DONE;
                        busy_q <= 1'b0;
                        hv_q   <= 1'b1;
                    end else begin
                        st        <= S_PERM;
                        lc        <= LC_INIT;
                        round_cnt <= '0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign bus.msg_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.hash_valid = hv_q;
    assign bus.hash       = hash_q;

endmodule

// File: tb/tb_spongent_stream.sv
// Directed bench for spongent_stream: default (R=16) and small (R=8) instances,
// digests checked against a bit-level reference model through a scoreboard.
module tb_spongent_stream;

    localparam int MB = 512;
    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
        4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
    };

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spongent_stream_if #(.R_BITS(16), .N(256)) bus_a ();
    spongent_stream_if #(.R_BITS(8),  .N(128)) bus_b ();

    spongent_stream #(.N(256), .C(256), .R_BITS(16), .ROUNDS(140)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    spongent_stream #(.N(128), .C(128), .R_BITS(8), .ROUNDS(70)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    int           tests = 0;
    int           fails = 0;
    logic [255:0] exp_q [$];
    logic [15:0]  msg_blk [16];
    int           msg_n;
    int           msg_k;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MB-1:0] m_perm(input logic [MB-1:0] s_in, input int b, input int rounds);
        logic [MB-1:0] s, t;
        logic [3:0]    nib;
        int            lc;
        s  = s_in;
        lc = 'h9E;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 8; i++) begin
                if (((lc >> i) & 1) != 0) begin
                    s[9'(i)]         = ~s[9'(i)];
                    s[9'(b - 1 - i)] = ~s[9'(b - 1 - i)];
                end
            end
            for (int n = 0; n < b / 4; n++) begin
                nib = s[9'(4 * n) +: 4];
                s[9'(4 * n) +: 4] = SBOX[nib];
            end
            t = '0;
            for (int j = 0; j < b - 1; j++) t[9'((j * b / 4) % (b - 1))] = s[9'(j)];
            t[9'(b - 1)] = s[9'(b - 1)];
            s  = t;
            lc = lc << 1;
            if ((lc & 'h100) != 0) lc = lc ^ 'h11D;
        end
        return s;
    endfunction

    function automatic logic [15:0] bswap(input logic [15:0] x, input int r);
        return (r == 16) ? {x[7:0], x[15:8]} : {8'h00, x[7:0]};
    endfunction

    function automatic logic [255:0] m_hash(input int r, input int c, input int n, input int rounds);
        logic [MB-1:0]  s;
        logic [15:0]    blk, pb;
        logic [255:0]   h;
        int             b;
        b = c + r;
        s = '0;
        for (int i = 0; i < msg_n; i++) begin
            blk = (r == 8) ? {8'h00, msg_blk[4'(i)][7:0]} : msg_blk[4'(i)];
            if (i == msg_n - 1) begin
                pb = '0;
                for (int p = 0; p < r; p++) begin
                    if (p < msg_k)       pb[4'(r - 1 - p)] = blk[4'(r - 1 - p)];
                    else if (p == msg_k) pb[4'(r - 1 - p)] = 1'b1;
                end
                blk = pb;
            end
            s[15:0] = s[15:0] ^ bswap(blk, r);
            s = m_perm(s, b, rounds);
        end
        if (msg_k == r) begin
            pb = 16'(1) << (r - 1);
            s[15:0] = s[15:0] ^ bswap(pb, r);
            s = m_perm(s, b, rounds);
        end
        h = '0;
        for (int k = 0; k < n / r; k++) begin
            h = (h << r) | 256'(bswap(s[15:0], r));
            if (k < n / r - 1) s = m_perm(s, b, rounds);
        end
        return h;
    endfunction

    function automatic logic rdy(input bit b);
        return b ? bus_b.msg_ready : bus_a.msg_ready;
    endfunction

    function automatic logic hv(input bit b);
        return b ? bus_b.hash_valid : bus_a.hash_valid;
    endfunction

    function automatic logic bsy(input bit b);
        return b ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic [255:0] hsh(input bit b);
        return b ? 256'(bus_b.hash) : bus_a.hash;
    endfunction

    task automatic pulse_start(input bit b);
        @(negedge clk);
        if (b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic send(input bit b, input logic [15:0] d, input bit last, input int k,
                        input int gap, output int hs);
        int w;
        w = 0;
        while (!rdy(b) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", 256'(rdy(b)), 256'(1));
        for (int g = 0; g < gap; g++) begin
            chk("gap_ready", 256'(rdy(b)), 256'(1));
            @(negedge clk);
        end
        if (b) begin
            bus_b.msg_valid = 1'b1; bus_b.msg_data = d[7:0];
            bus_b.msg_last = last;  bus_b.msg_last_bits = 4'(k);
        end else begin
            bus_a.msg_valid = 1'b1; bus_a.msg_data = d;
            bus_a.msg_last = last;  bus_a.msg_last_bits = 5'(k);
        end
        @(posedge clk);
        @(negedge clk);
        hs = cyc;
        bus_a.msg_valid = 1'b0; bus_a.msg_last = 1'b0;
        bus_b.msg_valid = 1'b0; bus_b.msg_last = 1'b0;
        chk("ready_drop", 256'(rdy(b)), 256'(0));
    endtask

    task automatic wait_hash(input bit b, input int hs, input int lat, input string tag);
        int           w;
        logic [255:0] exp;
        w = 0;
        while (!hv(b) && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_latency"}, 256'(cyc - hs), 256'(lat));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_digest"}, hsh(b), exp);
        chk({tag, "_busy_done"}, 256'(bsy(b)), 256'(0));
    endtask

    task automatic run_msg(input bit b, input int drv_k, input int gap, input string tag,
                           input bit start_in_perm);
        int hs, r, rounds, lat;
        r      = b ? 8 : 16;
        rounds = b ? 70 : 140;
        exp_q.push_back(b ? m_hash(8, 128, 128, 70) : m_hash(16, 256, 256, 140));
        pulse_start(b);
        chk({tag, "_start_ready"}, 256'(rdy(b)), 256'(1));
        chk({tag, "_start_hv"}, 256'(hv(b)), 256'(0));
        for (int i = 0; i < msg_n; i++)
            send(b, msg_blk[4'(i)], i == msg_n - 1, drv_k, gap, hs);
        if (start_in_perm) begin
            repeat (19) @(negedge clk);
            pulse_start(b);
            chk({tag, "_perm_busy"}, 256'(bsy(b)), 256'(1));
            chk({tag, "_perm_ready"}, 256'(rdy(b)), 256'(0));
        end
        lat = (128 * (b ? 1 : 2) / r) * (rounds + 1);
        lat = (b ? 128 : 256) / r * (rounds + 1) + ((msg_k == r) ? rounds + 1 : 0);
        wait_hash(b, hs, lat, tag);
    endtask

    initial begin
        int hs;
        int gaps [3];
        bus_a.start = 1'b0; bus_a.msg_valid = 1'b0; bus_a.msg_data = '0;
        bus_a.msg_last = 1'b0; bus_a.msg_last_bits = '0;
        bus_b.start = 1'b0; bus_b.msg_valid = 1'b0; bus_b.msg_data = '0;
        bus_b.msg_last = 1'b0; bus_b.msg_last_bits = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 256'(bus_a.msg_ready), 256'(0));
        chk("rst_busy", 256'(bus_a.busy), 256'(0));
        chk("rst_hv", 256'(bus_a.hash_valid), 256'(0));
        chk("rst_hash", bus_a.hash, 256'(0));
        rst = 1'b0;

        // Abort mid-permutation with reset
        pulse_start(1'b0);
        send(1'b0, 16'hBEEF, 1'b0, 0, 0, hs);
        repeat (49) @(negedge clk);
        chk("midperm_busy", 256'(bus_a.busy), 256'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 256'(bus_a.msg_ready), 256'(0));
        chk("abort_busy", 256'(bus_a.busy), 256'(0));
        chk("abort_hv", 256'(bus_a.hash_valid), 256'(0));
        chk("abort_hash", bus_a.hash, 256'(0));

        msg_n = 1; msg_blk[0] = 16'hA5C3; msg_k = 0;
        run_msg(1'b0, msg_k, 0, "empty", 1'b0);

        msg_n = 1; msg_blk[0] = 16'h1234; msg_k = 16;
        run_msg(1'b0, msg_k, 0, "full", 1'b0);

        msg_n = 3; msg_blk[0] = 16'h0F1E; msg_blk[1] = 16'h2D3C; msg_blk[2] = 16'h4B5A; msg_k = 11;
        gaps = '{0, 7, 300};
        for (int g = 0; g < 3; g++) run_msg(1'b0, msg_k, gaps[g], $sformatf("multi_gap%0d", gaps[g]), 1'b0);

        msg_n = 1; msg_blk[0] = 16'hC0DE; msg_k = 9;
        run_msg(1'b0, msg_k, 0, "start_perm", 1'b1);

        pulse_start(1'b0);
        chk("done_start_hv", 256'(bus_a.hash_valid), 256'(0));
        chk("done_start_ready", 256'(bus_a.msg_ready), 256'(1));
        chk("done_start_hash", bus_a.hash, 256'(0));

        // Out-of-range bit count behaves as a full final block
        msg_n = 1; msg_blk[0] = 16'h005A; msg_k = 8;
        run_msg(1'b1, 13, 0, "clamp", 1'b0);

        for (int m = 0; m < 30; m++) begin
            msg_n = int'($urandom_range(1, 3));
            for (int i = 0; i < msg_n; i++) msg_blk[4'(i)] = 16'($urandom);
            msg_k = int'($urandom_range(0, 8));
            run_msg(1'b1, msg_k, int'($urandom_range(0, 3)), $sformatf("rnd%0d", m), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
